// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a qualified lock, then releases the core reset.
// Optional macro PLL_SUP_LOL_RESTART_EN: loss of lock in RUN restarts the whole sequence.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RETRY_MAX     = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retries,
    output logic       lol,
    output logic [2:0] fsm_state
);

    localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIM = 4'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_PRST = 3'd0,
        S_WAIT = 3'd1,
        S_STAB = 3'd2,
        S_RUN  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      retries_n;
    logic            lol_n;
    logic            sync1, lock_s;

    // pll_locked is asynchronous; this pair is the only place it is sampled.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_locked;
            lock_s <= sync1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        retries_n = retries;
        lol_n     = lol;
        unique case (state)
            S_PRST: begin
                if (cnt == RST_LAST) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            S_WAIT: begin
                // Lock is checked before the timeout so a lock on the last cycle wins.
                if (lock_s) begin
                    state_n = S_STAB;
                    cnt_n   = '0;
                end else if (cnt == TO_LAST) begin
                    cnt_n = '0;
                    if (retries == RETRY_LIM) begin
                        state_n = S_FAIL;
                    end else begin
                        retries_n = retries + 4'd1;
                        state_n   = S_PRST;
                    end
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            S_STAB: begin
                if (!lock_s) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else if (cnt == STAB_LAST) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    lol_n = 1'b1;
`ifdef PLL_SUP_LOL_RESTART_EN
                    state_n = S_PRST;
                    cnt_n   = '0;
`endif
                end
            end
            S_FAIL: begin
                state_n = S_FAIL;
            end
            default: begin
                state_n = S_PRST;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_PRST;
            cnt       <= '0;
            retries   <= 4'd0;
            lol       <= 1'b0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retries   <= retries_n;
            lol       <= lol_n;
            pll_rst   <= (state_n == S_PRST) || (state_n == S_FAIL);
            sys_reset <= (state_n != S_RUN);
            ready     <= (state_n == S_RUN);
            fail      <= (state_n == S_FAIL);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: per-episode lock waveforms, a timeline model of the expected outputs,
// and an expected-value queue checked edge by edge.
module tb_pll_lock_supervisor;

    localparam int R    = 4;
    localparam int T    = 20;
    localparam int S    = 8;
    localparam int RM   = 2;
    localparam int MAXL = 256;

    localparam int C_PULSE = 0;
    localparam int C_WAIT  = 1;
    localparam int C_RUN   = 2;
    localparam int C_FAIL  = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_reset, ready, fail, lol;
    logic [3:0] retries;
    logic [2:0] fsm_state;

    int checks = 0;
    int failures = 0;

    bit         lk[MAXL];
    int         m_cat[MAXL];
    int         m_rt[MAXL];
    int         lol_at;
    logic [8:0] exp_q[$];

    int first_ready, first_fail;

    pll_lock_supervisor #(
        .RST_CYCLES(R), .LOCK_TIMEOUT(T), .STABLE_CYCLES(S), .RETRY_MAX(RM)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
        .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fail(fail),
        .retries(retries), .lol(lol), .fsm_state(fsm_state)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Synchronized lock as seen by the decision made at edge e (two flops of latency, cleared by reset).
    function automatic bit ls(input int e, input int len);
        return (e >= 3 && e - 2 < len) ? lk[e-2] : 1'b0;
    endfunction

    task automatic fill(input int a, input int b, input int c, input int rt, input int len);
        for (int e = a; e < b && e < len; e++) begin
            m_cat[e] = c;
            m_rt[e]  = rt;
        end
    endtask

    // Walks the timeline phase by phase: reset pulse, lock search, stable window, run / fail.
    task automatic build_model(input int len);
        int t, w, s, k, j, d, rt;
        bit timed_out, to_run;
        logic [8:0] v;
        t = 0; rt = 0; lol_at = MAXL;
        while (t < len) begin
            fill(t, t + R, C_PULSE, rt, len);
            w = t + R; to_run = 0; timed_out = 0;
            while (w < len && !to_run && !timed_out) begin
                k = 0;
                for (int i = 1; i <= T && k == 0; i++) if (ls(w + i, len)) k = i;
                if (k == 0) begin
                    fill(w, w + T, C_WAIT, rt, len);
                    timed_out = 1;
                end else begin
                    fill(w, w + k, C_WAIT, rt, len);
                    s = w + k; j = 0;
                    for (int i = 1; i <= S && j == 0; i++) if (!ls(s + i, len)) j = i;
                    fill(s, s + ((j == 0) ? S : j), C_WAIT, rt, len);
                    if (j == 0) begin to_run = 1; w = s + S; end
                    else w = s + j;
                end
            end
            if (timed_out) begin
                if (rt == RM) begin
                    fill(w + T, len, C_FAIL, rt, len);
                    t = len;
                end else begin
                    rt++;
                    t = w + T;
                end
            end else if (to_run) begin
                d = -1;
                for (int i = w + 1; i < len && d < 0; i++) if (!ls(i, len)) d = i;
                if (d < 0) begin
                    fill(w, len, C_RUN, rt, len);
                    t = len;
                end else begin
                    if (d < lol_at) lol_at = d;
`ifdef PLL_SUP_LOL_RESTART_EN
                    fill(w, d, C_RUN, rt, len);
                    t = d;
`else
                    fill(w, len, C_RUN, rt, len);
                    t = len;
`endif
                end
            end else begin
                t = len;
            end
        end
        exp_q.delete();
        for (int e = 0; e < len; e++) begin
            v[8]   = (m_cat[e] == C_PULSE) || (m_cat[e] == C_FAIL);
            v[7]   = (m_cat[e] != C_RUN);
            v[6]   = (m_cat[e] == C_RUN);
            v[5]   = (m_cat[e] == C_FAIL);
            v[4]   = (e >= lol_at);
            v[3:0] = 4'(m_rt[e]);
            exp_q.push_back(v);
        end
    endtask

    task automatic set_lk_from(input int len, input int on_from);
        for (int e = 0; e < MAXL; e++) lk[e] = (e < len) && (e >= on_from);
    endtask

    task automatic gen_random(input int len);
        int e, seg;
        bit v;
        for (int i = 0; i < MAXL; i++) lk[i] = 1'b0;
        e = 0;
        while (e < len) begin
            v   = 1'($urandom_range(0, 1));
            seg = v ? $urandom_range(1, 50) : $urandom_range(1, 30);
            for (int i = 0; i < seg && e < len; i++) begin
                lk[e] = v;
                e++;
            end
        end
    endtask

    // Edge 0 of every episode carries rst=1, so each episode also resets whatever state came before.
    task automatic run_episode(input int ep, input int len);
        logic [8:0] obs, expv;
        build_model(len);
        first_ready = -1;
        first_fail  = -1;
        for (int e = 0; e < len; e++) begin
            @(negedge refclk);
            rst        = (e == 0);
            pll_locked = lk[e];
            @(posedge refclk);
            #1;
            obs = {pll_rst, sys_reset, ready, fail, lol, retries};
            if (exp_q.size() == 0) begin
                check($sformatf("ep%0d_e%0d_queue", ep, e), 32'd0, 32'd1);
            end else begin
                expv = exp_q.pop_front();
                check($sformatf("ep%0d_e%0d_outs", ep, e), 32'(obs), 32'(expv));
            end
            check($sformatf("ep%0d_e%0d_state_known", ep, e), 32'($isunknown(fsm_state)), 32'd0);
            if (ready && first_ready < 0) first_ready = e;
            if (fail && first_fail < 0) first_fail = e;
        end
    endtask

    initial begin
        // Normal bring-up: lock from edge 10.
        set_lk_from(40, 10);
        run_episode(1, 40);
        check("ep1_first_ready", 32'(first_ready), 32'd20);
        check("ep1_retries", 32'(retries), 32'd0);

        // One-cycle glitch during the stable window.
        set_lk_from(40, 10);
        lk[14] = 1'b0;
        run_episode(2, 40);
        check("ep2_first_ready", 32'(first_ready), 32'd25);
        check("ep2_retries", 32'(retries), 32'd0);

        // Lock never arrives: all attempts time out.
        set_lk_from(90, MAXL);
        run_episode(3, 90);
        check("ep3_first_fail", 32'(first_fail), 32'd72);
        check("ep3_retries", 32'(retries), 32'd2);
        check("ep3_pll_rst", 32'(pll_rst), 32'd1);
        check("ep3_sys_reset", 32'(sys_reset), 32'd1);

        // Late lock during the second wait window; reset taken from FAIL.
        set_lk_from(60, 35);
        run_episode(4, 60);
        check("ep4_first_ready", 32'(first_ready), 32'd45);
        check("ep4_retries", 32'(retries), 32'd1);

        // Loss of lock while running.
        set_lk_from(60, 5);
        lk[30] = 1'b0;
        run_episode(5, 60);
        check("ep5_lol", 32'(lol), 32'd1);
        check("ep5_ready_end", 32'(ready), 32'd1);
        check("ep5_sys_reset_end", 32'(sys_reset), 32'd0);

        for (int ep = 6; ep < 16; ep++) begin
            int len;
            len = $urandom_range(60, 200);
            gen_random(len);
            run_episode(ep, len);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
